// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, IF/ID register.
// Redirects outrank stalls; a redirect that lands during an outstanding
// fetch is latched and applied when that fetch's ack finally arrives.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        if_id_write,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_in,
   output logic        PCWrite,
   output logic [31:0] PC_out,
   output logic [31:0] instruction_out,
   output logic [31:0] IF_ID_instruction,
   output logic [31:0] IF_ID_PC_plus4,
   output logic        IF_ID_valid
);

   typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, pc_plus4, tgt_al;
   logic [31:0] hold_buf, pend_tgt, ifid_word;
   logic        pend;
   logic        ack, run;
   logic        pc_ld, ifid_ld, ifid_bub, buf_ld, word_acc, pend_set, pend_clr;

   // An ack only counts while a request is actually out
   assign ack      = imem_ack && (state == S_FETCH);
   assign run      = pc_write && if_id_write;
   assign pc_plus4 = pc + 32'd4;
   assign tgt_al   = {redirect_target[31:2], 2'b00};
   assign ifid_word = (state == S_HOLD) ? hold_buf : imem_rdata;

   assign PC_out    = pc;
   assign imem_addr = pc;
   assign PC_in     = rst ? RESET_PC : pc_nx;
   assign PCWrite   = rst | pc_ld;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_RST;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_RST:   state_nx = S_FETCH;
         S_FETCH: if (ack && !redirect && !pend && !run) state_nx = S_HOLD;
         S_HOLD:  if (redirect || run) state_nx = S_FETCH;
         default: state_nx = S_RST;
      endcase
   end

   // Output / datapath control decode
   always_comb begin
      imem_req = 1'b0;
      pc_ld    = 1'b0;
      pc_nx    = pc;
      ifid_ld  = 1'b0;
      ifid_bub = 1'b0;
      buf_ld   = 1'b0;
      word_acc = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               ifid_bub = 1'b1;
               if (ack) begin
                  pc_ld    = 1'b1;
                  pc_nx    = tgt_al;
                  pend_clr = 1'b1;
               end else begin
                  pend_set = 1'b1;
               end
            end else if (pend) begin
               // Wrong-path fetch still in flight: drop its data when it lands
               if (if_id_write) ifid_bub = 1'b1;
               if (ack) begin
                  pc_ld    = 1'b1;
                  pc_nx    = pend_tgt;
                  pend_clr = 1'b1;
               end
            end else if (ack) begin
               word_acc = 1'b1;
               if (run) begin
                  ifid_ld = 1'b1;
                  pc_ld   = 1'b1;
                  pc_nx   = pc_plus4;
               end else begin
                  buf_ld = 1'b1;
                  if (if_id_write) ifid_bub = 1'b1;
               end
            end else if (if_id_write) begin
               ifid_bub = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               ifid_bub = 1'b1;
               pc_ld    = 1'b1;
               pc_nx    = tgt_al;
            end else if (run) begin
               ifid_ld = 1'b1;
               pc_ld   = 1'b1;
               pc_nx   = pc_plus4;
            end else if (if_id_write) begin
               ifid_bub = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // PC, accepted word, hold buffer, pending redirect and IF/ID registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc                <= RESET_PC;
         instruction_out   <= 32'd0;
         hold_buf          <= 32'd0;
         pend              <= 1'b0;
         pend_tgt          <= 32'd0;
         IF_ID_instruction <= NOP_INSTR;
         IF_ID_PC_plus4    <= 32'd0;
         IF_ID_valid       <= 1'b0;
      end else begin
         if (pc_ld)    pc              <= pc_nx;
         if (word_acc) instruction_out <= imem_rdata;
         if (buf_ld)   hold_buf        <= imem_rdata;
         if (pend_set) begin
            pend     <= 1'b1;
            pend_tgt <= tgt_al;
         end else if (pend_clr) begin
            pend <= 1'b0;
         end
         if (ifid_ld) begin
            IF_ID_instruction <= ifid_word;
            IF_ID_PC_plus4    <= pc_plus4;
            IF_ID_valid       <= 1'b1;
         end else if (ifid_bub) begin
            IF_ID_instruction <= NOP_INSTR;
            IF_ID_valid       <= 1'b0;
         end
      end
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that drives the CPU's front end: owns the PC register, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register (instruction, PC+4, valid). It produces the fetch-side signals the CPU bench monitors (PC_in, PCWrite, PC_out, instruction_out, IF_ID_instruction, IF_ID_PC_plus4). Stall comes from the hazard unit, redirect/flush from the branch resolution logic in ID/EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_write  in  1  hazard-unit enable; 0 = stall PC
if_id_write  in  1  hazard-unit enable; 0 = hold IF/ID
redirect  in  1  branch/jump taken: flush IF/ID, load PC from target
redirect_target  in  32  new PC; bits [1:0] forced to 0 internally
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (= PC_out)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
PC_in  out  32  combinational next-PC value
PCWrite  out  1  combinational: PC register loads this cycle
PC_out  out  32  current PC
instruction_out  out  32  last word accepted from memory
IF_ID_instruction  out  32  IF/ID instruction
IF_ID_PC_plus4  out  32  IF/ID PC+4
IF_ID_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset, applied on any edge with rst=1 and overriding all else: PC_out=RESET_PC, imem_req=0, instruction_out=0, IF_ID_instruction=NOP_INSTR, IF_ID_PC_plus4=0, IF_ID_valid=0, redirect_pending=0, hold buffer cleared, state=S_RST.
- States: S_RST, S_FETCH, S_HOLD.
- S_RST: imem_req=0. Next edge goes to S_FETCH. First request appears 1 cycle after rst falls.
- S_FETCH: imem_req=1, imem_addr=PC_out. imem_addr must stay stable while req=1 and ack=0.
  - ack=1, no redirect, no pending redirect, pc_write=1, if_id_write=1: IF/ID <= {imem_rdata, PC_out+4, valid=1}; PC <= PC_out+4; instruction_out <= imem_rdata. Stay in S_FETCH. Throughput is 1 instr/cycle with 0-wait memory.
  - ack=1 with stall (pc_write=0 or if_id_write=0): store the word in the hold buffer; instruction_out <= imem_rdata; go to S_HOLD. IF/ID is unchanged if if_id_write=0.
  - ack=0 with if_id_write=1: IF/ID <= bubble (NOP_INSTR, valid=0). PC is unchanged.
- S_HOLD: imem_req=0. When pc_write=1 and if_id_write=1, load IF/ID from the buffer, PC <= PC_out+4, go to S_FETCH.
- Redirect, which has priority over stall:
  - IF/ID <= bubble.
  - If no fetch is outstanding (S_HOLD, or S_FETCH with ack=1 the same cycle): PC <= {target[31:2],2'b00}, discard any returned/buffered word, go to S_FETCH.
  - If S_FETCH with ack=0: latch the target, set redirect_pending, keep addr stable. On the later ack, discard the data, load PC from the latched target, clear pending.
  - A new redirect while one is pending overwrites the latched target.
- PCWrite=1 exactly on edges where the PC register loads. PC_in is the value it will load, otherwise PC_out.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- imem_ack while imem_req=0 is ignored.
- rst mid-fetch aborts the fetch: imem_req=0 on the next cycle, and a late ack is ignored.

Test Plan:
- rst high 2 cycles then low, 0-wait memory returning addr-based words: PC_out sequence 0,4,8,12; IF_ID_PC_plus4 sequence 4,8,12; IF_ID_valid=1 from the 2nd post-reset edge.
- Memory with 2 wait cycles: imem_addr stays 0x0 for 3 cycles; IF/ID shows bubbles (valid=0, NOP) until ack; PC_out=4 only after ack.
- Stall: pc_write=if_id_write=0 on ack of addr 0x8 for 3 cycles → state S_HOLD, PC_out stays 0x8, IF/ID unchanged; on release IF_ID_instruction=word@0x8, PC_out=0xC.
- Redirect to 0x103 during an outstanding fetch of 0x10 → returned word discarded, IF_ID_valid=0, next imem_addr=0x100.
- PC at 0xFFFF_FFFC with fetch accepted → PC_out=0x0, IF_ID_PC_plus4=0x0.
- rst asserted mid-wait → all outputs at reset values on the next edge; a later ack is ignored; fetch restarts at RESET_PC.
